// File: rtl/univ_shift_engine.sv
// Universal N-bit shift register with STEP-bit granule, command handshake and burst mode.
// Define USR_ROTATE_EN to build the rotate opcodes (100/101); otherwise they behave as nop.
module univ_shift_engine #(
   parameter int N    = 8,
   parameter int STEP = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [2:0]      ctrl,
   input  logic [N-1:0]    d,
   input  logic [STEP-1:0] si,
   output logic [N-1:0]    q,
   output logic [STEP-1:0] so,
   output logic            busy,
   output logic            done
);

   localparam int WORDS = N / STEP;
   localparam int CW    = $clog2(WORDS) + 1;

   typedef enum logic {IDLE, BURST} state_t;

   state_t         state;
   logic [N-1:0]   r_reg;
   logic [CW-1:0]  cnt;
   logic [N-1:0]   shl_val;
   logic [N-1:0]   op_next;

   assign shl_val   = {r_reg[N-STEP-1:0], si};
   assign q         = r_reg;
   assign so        = r_reg[N-1 -: STEP];
   assign busy      = (state == BURST);
   assign cmd_ready = (state == IDLE);

   // Result of a single-cycle opcode; unused/unbuilt opcodes hold the register.
   always_comb begin
      op_next = r_reg;
      case (ctrl)
         3'b001:  op_next = shl_val;
         3'b010:  op_next = {si, r_reg[N-1:STEP]};
         3'b011:  op_next = d;
`ifdef USR_ROTATE_EN
         3'b100:  op_next = {r_reg[N-STEP-1:0], r_reg[N-1 -: STEP]};
         3'b101:  op_next = {r_reg[STEP-1:0], r_reg[N-1:STEP]};
`endif
         3'b110:  op_next = {{STEP{r_reg[N-1]}}, r_reg[N-1:STEP]};
         default: op_next = r_reg;
      endcase
   end

   // Burst loads on accept, then shifts once per edge until the count runs out.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_reg <= '0;
         state <= IDLE;
         cnt   <= '0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  if (ctrl == 3'b111) begin
                     r_reg <= d;
                     cnt   <= CW'(WORDS);
                     state <= BURST;
                  end else begin
                     r_reg <= op_next;
                  end
               end
            end
            BURST: begin
               r_reg <= shl_val;
               cnt   <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  state <= IDLE;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_univ_shift_engine.sv
// Directed bench for univ_shift_engine: an N=8/STEP=1 instance for basic ops and an
// N=8/STEP=2 instance for rotate, burst, lockout, back-to-back and reset-abort cases.
module tb_univ_shift_engine;

   logic       clk = 1'b0;
   logic       reset = 1'b0;

   logic       a_valid = 1'b0;
   logic       a_ready;
   logic [2:0] a_ctrl = 3'b000;
   logic [7:0] a_d = 8'h00;
   logic [0:0] a_si = 1'b0;
   logic [7:0] a_q;
   logic [0:0] a_so;
   logic       a_busy;
   logic       a_done;

   logic       b_valid = 1'b0;
   logic       b_ready;
   logic [2:0] b_ctrl = 3'b000;
   logic [7:0] b_d = 8'h00;
   logic [1:0] b_si = 2'b00;
   logic [7:0] b_q;
   logic [1:0] b_so;
   logic       b_busy;
   logic       b_done;

   int compared   = 0;
   int mismatched = 0;

   logic [7:0] rot_l_exp;
   logic [7:0] rot_r_exp;
   logic [1:0] si_tab [4];
   logic [7:0] q_tab  [4];
   logic [1:0] so_tab [4];

   always #5 clk = ~clk;

   univ_shift_engine #(.N(8), .STEP(1)) u_step1 (
      .clk(clk), .reset(reset), .cmd_valid(a_valid), .cmd_ready(a_ready),
      .ctrl(a_ctrl), .d(a_d), .si(a_si), .q(a_q), .so(a_so),
      .busy(a_busy), .done(a_done)
   );

   univ_shift_engine #(.N(8), .STEP(2)) u_step2 (
      .clk(clk), .reset(reset), .cmd_valid(b_valid), .cmd_ready(b_ready),
      .ctrl(b_ctrl), .d(b_d), .si(b_si), .q(b_q), .so(b_so),
      .busy(b_busy), .done(b_done)
   );

   // Advance one edge and settle so outputs are sampled away from the clock edge.
   task automatic apply_stimulus();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
`ifdef USR_ROTATE_EN
      rot_l_exp = 8'h0F;
      rot_r_exp = 8'hC3;
`else
      rot_l_exp = 8'hC3;
      rot_r_exp = 8'hC3;
`endif
      si_tab = '{2'd3, 2'd0, 2'd1, 2'd2};
      q_tab  = '{8'hD3, 8'h4C, 8'h31, 8'hC6};
      so_tab = '{2'd3, 2'd1, 2'd0, 2'd3};

      // Reset asserted mid-cycle, held across two edges.
      #3 reset = 1'b1;
      apply_stimulus();
      apply_stimulus();
      reset = 1'b0;
      check_output("rst_q",     a_q,     8'h00);
      check_output("rst_ready", a_ready, 1'b1);
      check_output("rst_busy",  a_busy,  1'b0);
      check_output("rst_done",  a_done,  1'b0);
      check_output("rst_so",    b_so,    2'b00);

      // Basic ops on STEP=1.
      a_valid = 1'b1; a_ctrl = 3'b011; a_d = 8'hA5;
      apply_stimulus();
      check_output("load_a5", a_q, 8'hA5);
      a_ctrl = 3'b001; a_si = 1'b1;
      apply_stimulus();
      check_output("shl", a_q, 8'h4B);
      a_ctrl = 3'b010; a_si = 1'b0;
      apply_stimulus();
      check_output("shr", a_q, 8'h25);
      a_ctrl = 3'b110; a_si = 1'b1;
      apply_stimulus();
      check_output("ashr", a_q, 8'h12);
      a_valid = 1'b0; a_ctrl = 3'b001;
      apply_stimulus();
      check_output("hold_no_valid", a_q, 8'h12);

      // Rotate on STEP=2.
      b_valid = 1'b1; b_ctrl = 3'b011; b_d = 8'hC3;
      apply_stimulus();
      check_output("load_c3", b_q, 8'hC3);
      b_ctrl = 3'b100;
      apply_stimulus();
      check_output("rotl", b_q, rot_l_exp);
      check_output("rotl_ready", b_ready, 1'b1);
      b_ctrl = 3'b101;
      apply_stimulus();
      check_output("rotr", b_q, rot_r_exp);

      // Plain burst, d=B4, si 3,0,1,2.
      b_ctrl = 3'b111; b_d = 8'hB4;
      apply_stimulus();
      b_valid = 1'b0;
      check_output("burst_load_q",  b_q,    8'hB4);
      check_output("burst_so0",     b_so,   2'd2);
      check_output("burst_busy0",   b_busy, 1'b1);
      check_output("burst_ready0",  b_ready, 1'b0);
      for (int k = 0; k < 4; k++) begin
         b_si = si_tab[k];
         apply_stimulus();
         check_output($sformatf("burst_q%0d", k),    b_q,    q_tab[k]);
         check_output($sformatf("burst_so%0d", k+1), b_so,   so_tab[k]);
         check_output($sformatf("burst_busy%0d", k+1), b_busy, (k < 3) ? 1'b1 : 1'b0);
         check_output($sformatf("burst_done%0d", k+1), b_done, (k == 3) ? 1'b1 : 1'b0);
      end
      apply_stimulus();
      check_output("burst_done_once", b_done, 1'b0);
      check_output("burst_q_hold",    b_q,    8'hC6);

      // Burst with a load 0xFF pushed during the shifts: must be ignored.
      b_valid = 1'b1; b_ctrl = 3'b111; b_d = 8'hB4;
      apply_stimulus();
      b_ctrl = 3'b011; b_d = 8'hFF;
      for (int k = 0; k < 4; k++) begin
         b_si = si_tab[k];
         if (k == 3) b_valid = 1'b0;
         apply_stimulus();
         check_output($sformatf("lock_q%0d", k), b_q, q_tab[k]);
      end
      check_output("lock_done", b_done, 1'b1);

      // Second burst issued in the done cycle.
      b_valid = 1'b1; b_ctrl = 3'b111; b_d = 8'h5A; b_si = 2'd1;
      apply_stimulus();
      b_valid = 1'b0;
      check_output("b2b_q",    b_q,    8'h5A);
      check_output("b2b_busy", b_busy, 1'b1);
      check_output("b2b_done", b_done, 1'b0);
      apply_stimulus();
      check_output("b2b_shift1", b_q, 8'h69);
      apply_stimulus();
      check_output("b2b_shift2", b_q, 8'hA5);

      // Reset after two shifts aborts the burst.
      reset = 1'b1;
      apply_stimulus();
      reset = 1'b0;
      check_output("abort_q",     b_q,     8'h00);
      check_output("abort_busy",  b_busy,  1'b0);
      check_output("abort_ready", b_ready, 1'b1);
      check_output("abort_done",  b_done,  1'b0);
      for (int k = 0; k < 4; k++) begin
         apply_stimulus();
         check_output($sformatf("abort_no_done%0d", k), b_done, 1'b0);
      end
      b_valid = 1'b1; b_ctrl = 3'b011; b_d = 8'h3C;
      apply_stimulus();
      b_valid = 1'b0;
      check_output("post_abort_load", b_q, 8'h3C);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
